// File: rtl/servo_pwm_capture.sv
// Measures the high time of an RC/servo PWM input in microseconds and flags range/loss errors.
// Optional glitch filter between synchroniser and edge detection: define PWM_FILTER_EN.
module servo_pwm_capture #(
    parameter int CLKS_PER_US = 50,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int TIMEOUT_US  = 25000,
    parameter int FILT_CLKS   = 8
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [15:0] pul_len,
    output logic        pul_valid,
    output logic        err_range,
    output logic        sig_lost
);
    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [15:0] MIN_W = 16'(MIN_US);
    localparam logic [15:0] MAX_W = 16'(MAX_US);
    localparam logic [14:0] TO_LIM = 15'(TIMEOUT_US);
    // After reset the pipeline reads low until the pin value has propagated; WAIT_LOW
    // must outlast that so a pulse already in progress is never taken as a fresh rise.
`ifdef PWM_FILTER_EN
    localparam int SETTLE = 3 + FILT_CLKS;
`else
    localparam int SETTLE = 3;
`endif
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } state_t;

    state_t          state_r;
    logic            sync1_r;
    logic            sync2_r;
    logic            lvl_s;
    logic            lvl_prev_r;
    logic            rise_s;
    logic            fall_s;
    logic [PW-1:0]   presc_r;
    logic            us_tick_s;
    logic [15:0]     w_r;
    logic [15:0]     w_eff_s;
    logic            accept_s;
    logic [14:0]     tcnt_r;
    logic [SW-1:0]   settle_r;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_FILTER_EN
    localparam int FW = $clog2(FILT_CLKS + 1);
    logic          filt_r;
    logic [FW-1:0] filt_cnt_r;

    // Filtered level flips only after s_in disagrees with it for FILT_CLKS consecutive cycles
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            filt_r     <= 1'b0;
            filt_cnt_r <= {FW{1'b0}};
        end else if (sync2_r == filt_r) begin
            filt_cnt_r <= {FW{1'b0}};
        end else if (filt_cnt_r == FW'(FILT_CLKS - 1)) begin
            filt_r     <= sync2_r;
            filt_cnt_r <= {FW{1'b0}};
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
        end
    end
    assign lvl_s = filt_r;
`else
    assign lvl_s = sync2_r;
`endif

    assign rise_s    = lvl_s & ~lvl_prev_r;
    assign fall_s    = ~lvl_s & lvl_prev_r;
    assign us_tick_s = (presc_r == PRESC_LAST) && !rise_s;

    // Edge-detect history and microsecond prescaler, realigned on every rising edge
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            lvl_prev_r <= 1'b0;
            presc_r    <= {PW{1'b0}};
        end else begin
            lvl_prev_r <= lvl_s;
            if (rise_s || (presc_r == PRESC_LAST)) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Width including a tick landing on the falling-edge cycle gives floor(high_clocks / CLKS_PER_US)
    always_comb begin
        w_eff_s  = w_r;
        accept_s = 1'b0;
        if (us_tick_s && (w_r != 16'hFFFF)) begin
            w_eff_s = w_r + 16'd1;
        end else begin
            w_eff_s = w_r;
        end
        if ((state_r == HIGH) && fall_s && (w_eff_s >= MIN_W) && (w_eff_s <= MAX_W)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Measurement FSM with registered result, error and loss-of-signal outputs
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r   <= WAIT_LOW;
            w_r       <= 16'd0;
            settle_r  <= {SW{1'b0}};
            tcnt_r    <= 15'd0;
            pul_len   <= 16'd1500;
            pul_valid <= 1'b0;
            err_range <= 1'b0;
            sig_lost  <= 1'b1;
        end else begin
            pul_valid <= 1'b0;
            case (state_r)
                WAIT_LOW: begin
                    w_r <= 16'd0;
                    if (lvl_s) begin
                        settle_r <= {SW{1'b0}};
                    end else if (settle_r == SETTLE_LAST) begin
                        settle_r <= {SW{1'b0}};
                        state_r  <= IDLE;
                    end else begin
                        settle_r <= settle_r + SW'(1);
                    end
                end
                IDLE: begin
                    if (rise_s) begin
                        w_r     <= 16'd0;
                        state_r <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        state_r <= IDLE;
                        if (accept_s) begin
                            pul_len   <= w_eff_s;
                            pul_valid <= 1'b1;
                            err_range <= 1'b0;
                        end else begin
                            err_range <= 1'b1;
                        end
                    end else if (w_eff_s > MAX_W) begin
                        err_range <= 1'b1;
                        state_r   <= WAIT_LOW;
                    end else begin
                        w_r <= w_eff_s;
                    end
                end
                default: begin
                    state_r <= WAIT_LOW;
                end
            endcase

            if (accept_s) begin
                tcnt_r   <= 15'd0;
                sig_lost <= 1'b0;
            end else if (tcnt_r == TO_LIM) begin
                sig_lost <= 1'b1;
            end else if (us_tick_s) begin
                tcnt_r <= tcnt_r + 15'd1;
                if ((tcnt_r + 15'd1) == TO_LIM) begin
                    sig_lost <= 1'b1;
                end
            end
        end
    end
endmodule
